// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: shares one write port between the ALU and
// memory-load paths and tracks per-register pending writes for hazard detection.
module regfile_wb_arbiter #(
  parameter int NREG     = 32,
  parameter int DW       = 32,
  parameter int ZERO_REG = 1,
  parameter int RR_EN    = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    alu_valid,
  output logic                    alu_ready,
  input  logic [$clog2(NREG)-1:0] alu_addr,
  input  logic [DW-1:0]           alu_data,
  input  logic                    mem_valid,
  output logic                    mem_ready,
  input  logic [$clog2(NREG)-1:0] mem_addr,
  input  logic [DW-1:0]           mem_data,
  input  logic                    issue_valid,
  input  logic [$clog2(NREG)-1:0] issue_addr,
  input  logic [$clog2(NREG)-1:0] rd_addra,
  input  logic [$clog2(NREG)-1:0] rd_addrb,
  output logic                    hazard_a,
  output logic                    hazard_b,
  output logic [NREG-1:0]         busy_mask,
  output logic                    enc,
  output logic [$clog2(NREG)-1:0] addrc,
  output logic [DW-1:0]           datac
);

  localparam int AW = $clog2(NREG);
  localparam logic GNT_ALU = 1'b0;
  localparam logic GNT_MEM = 1'b1;

  logic          last_grant_reg;
  logic          alu_win;
  logic          mem_win;
  logic          xfer;
  logic          wr_ok;
  logic          issue_ok;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic          enc_reg;
  logic [AW-1:0] addrc_reg;
  logic [DW-1:0] datac_reg;
  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Grants depend only on the valids and the round-robin pointer.
  always_comb begin
    alu_win = 1'b0;
    mem_win = 1'b0;
    if (alu_valid && mem_valid) begin
      if (RR_EN != 0 && last_grant_reg == GNT_MEM) alu_win = 1'b1;
      else                                         mem_win = 1'b1;
    end else begin
      alu_win = alu_valid;
      mem_win = mem_valid;
    end
  end

  assign alu_ready = reset & alu_win;
  assign mem_ready = reset & mem_win;
  assign xfer      = alu_ready | mem_ready;
  assign win_addr  = mem_win ? mem_addr : alu_addr;
  assign win_data  = mem_win ? mem_data : alu_data;
  // A write to the hardwired zero register completes the handshake but is discarded.
  assign wr_ok     = xfer && !(ZERO_REG != 0 && win_addr == '0);
  assign issue_ok  = issue_valid && !(ZERO_REG != 0 && issue_addr == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enc_reg        <= 1'b0;
      addrc_reg      <= '0;
      datac_reg      <= '0;
      last_grant_reg <= GNT_MEM;
    end else begin
      enc_reg <= wr_ok;
      if (wr_ok) begin
        addrc_reg <= win_addr;
        datac_reg <= win_data;
      end
      if (xfer) last_grant_reg <= mem_win ? GNT_MEM : GNT_ALU;
    end
  end

  // Set beats clear so a re-issue on the commit edge keeps the register pending.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
      assign busy_next[gi] = (issue_ok && issue_addr == AW'(gi)) |
                             (busy_reg[gi] & ~(enc_reg && addrc_reg == AW'(gi)));
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy_mask = busy_reg;
  assign hazard_a  = busy_reg[rd_addra];
  assign hazard_b  = busy_reg[rd_addrb];
  assign enc       = enc_reg;
  assign addrc     = addrc_reg;
  assign datac     = datac_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a round-robin and a fixed-priority
// instance share stimulus and are checked every cycle against a behavioural model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]  alu_addr = '0, mem_addr = '0, issue_addr = '0, rd_addra = '0, rd_addrb = '0;
  logic [31:0] alu_data = '0, mem_data = '0;

  logic        alu_ready [2];
  logic        mem_ready [2];
  logic        hazard_a  [2];
  logic        hazard_b  [2];
  logic [31:0] busy_mask [2];
  logic        enc       [2];
  logic [4:0]  addrc     [2];
  logic [31:0] datac     [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREG(32), .DW(32), .ZERO_REG(1), .RR_EN(1)) dut_rr (
    .clock(clk), .reset(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready[0]), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready[0]), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addra(rd_addra), .rd_addrb(rd_addrb),
    .hazard_a(hazard_a[0]), .hazard_b(hazard_b[0]), .busy_mask(busy_mask[0]),
    .enc(enc[0]), .addrc(addrc[0]), .datac(datac[0])
  );

  regfile_wb_arbiter #(.NREG(32), .DW(32), .ZERO_REG(1), .RR_EN(0)) dut_fp (
    .clock(clk), .reset(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready[1]), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready[1]), .mem_addr(mem_addr), .mem_data(mem_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addra(rd_addra), .rd_addrb(rd_addrb),
    .hazard_a(hazard_a[1]), .hazard_b(hazard_b[1]), .busy_mask(busy_mask[1]),
    .enc(enc[1]), .addrc(addrc[1]), .datac(datac[1])
  );

  // Model state per instance: 0 = round-robin, 1 = MEM-priority.
  // Requester codes: 0 none, 1 ALU, 2 MEM.
  int          m_last [2];
  bit          m_wr   [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  logic [31:0] m_busy [2];

  function automatic int who_wins(int k);
    if (!rst_n) return 0;
    if (alu_valid && mem_valid) begin
      if (k == 1) return 2;
      return (m_last[k] == 2) ? 1 : 2;
    end
    if (alu_valid) return 1;
    if (mem_valid) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_last[k] = 2; m_wr[k] = 0; m_addr[k] = '0; m_data[k] = '0; m_busy[k] = '0;
      end else begin
        int w;
        logic [4:0] a;
        w = who_wins(k);
        if (m_wr[k]) m_busy[k][m_addr[k]] = 1'b0;
        if (issue_valid && issue_addr != 0) m_busy[k][issue_addr] = 1'b1;
        m_wr[k] = 0;
        if (w != 0) begin
          m_last[k] = w;
          a = (w == 1) ? alu_addr : mem_addr;
          if (a != 0) begin
            m_wr[k]   = 1;
            m_addr[k] = a;
            m_data[k] = (w == 1) ? alu_data : mem_data;
          end
        end
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int w;
      w = who_wins(k);
      check($sformatf("m%0d alu_ready", k), {31'd0, alu_ready[k]}, {31'd0, w == 1});
      check($sformatf("m%0d mem_ready", k), {31'd0, mem_ready[k]}, {31'd0, w == 2});
      check($sformatf("m%0d enc", k), {31'd0, enc[k]}, {31'd0, m_wr[k]});
      check($sformatf("m%0d busy_mask", k), busy_mask[k], m_busy[k]);
      check($sformatf("m%0d hazard_a", k), {31'd0, hazard_a[k]}, {31'd0, m_busy[k][rd_addra]});
      check($sformatf("m%0d hazard_b", k), {31'd0, hazard_b[k]}, {31'd0, m_busy[k][rd_addrb]});
      if (m_wr[k]) begin
        check($sformatf("m%0d addrc", k), {27'd0, addrc[k]}, {27'd0, m_addr[k]});
        check($sformatf("m%0d datac", k), datac[k], m_data[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rr_addr [4];

  initial begin
    rr_addr[0] = 5'd3; rr_addr[1] = 5'd4; rr_addr[2] = 5'd3; rr_addr[3] = 5'd4;

    // Reset held with ALU requesting.
    alu_valid = 1'b1; alu_addr = 5'd1; alu_data = 32'h0000_0011;
    repeat (3) begin
      @(negedge clk);
      check("rst alu_ready", {31'd0, alu_ready[0]}, 32'd0);
      check("rst enc", {31'd0, enc[0]}, 32'd0);
      check("rst busy_mask", busy_mask[0], 32'd0);
      check("rst addrc", {27'd0, addrc[0]}, 32'd0);
      check("rst datac", datac[0], 32'd0);
    end
    rst_n = 1'b1;
    #1;
    check("release alu_ready", {31'd0, alu_ready[0]}, 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("first write addrc", {27'd0, addrc[0]}, 32'd1);

    // Single write with a RAW hazard on register 5.
    tick();
    issue_valid = 1'b1; issue_addr = 5'd5; rd_addra = 5'd5;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("single hazard_a pending", {31'd0, hazard_a[0]}, 32'd1);
    tick();
    alu_valid = 1'b0;
    @(negedge clk);
    check("single enc", {31'd0, enc[0]}, 32'd1);
    check("single addrc", {27'd0, addrc[0]}, 32'd5);
    check("single datac", datac[0], 32'hDEAD_BEEF);
    tick();
    @(negedge clk);
    check("single hazard_a cleared", {31'd0, hazard_a[0]}, 32'd0);

    // Zero register: issue ignored, write handshakes but never reaches the port.
    tick();
    issue_valid = 1'b1; issue_addr = 5'd0;
    tick();
    issue_valid = 1'b0;
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'h0000_1234; rd_addrb = 5'd0;
    @(negedge clk);
    check("zero mem_ready", {31'd0, mem_ready[0]}, 32'd1);
    check("zero busy0", {31'd0, busy_mask[0][0]}, 32'd0);
    check("zero hazard_b", {31'd0, hazard_b[0]}, 32'd0);
    tick();
    mem_valid = 1'b0;
    @(negedge clk);
    check("zero enc", {31'd0, enc[0]}, 32'd0);

    // Both requesting: alternation on the RR instance, MEM always on the other.
    tick();
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hA000_0003;
    mem_valid = 1'b1; mem_addr = 5'd4; mem_data = 32'hB000_0004;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check($sformatf("rr%0d alu_ready", i), {31'd0, alu_ready[0]}, {31'd0, (i % 2) == 0});
        check($sformatf("rr%0d mem_ready", i), {31'd0, mem_ready[0]}, {31'd0, (i % 2) == 1});
        check($sformatf("fp%0d mem_ready", i), {31'd0, mem_ready[1]}, 32'd1);
        check($sformatf("fp%0d alu_ready", i), {31'd0, alu_ready[1]}, 32'd0);
      end
      if (i > 0) begin
        check($sformatf("rr%0d enc", i), {31'd0, enc[0]}, 32'd1);
        check($sformatf("rr%0d addrc", i), {27'd0, addrc[0]}, {27'd0, rr_addr[i-1]});
      end
      if (i < 4) tick();
      if (i == 3) begin
        alu_valid = 1'b0; mem_valid = 1'b0;
      end
    end

    // Set and clear of register 7 on the same edge: set wins.
    tick();
    issue_valid = 1'b1; issue_addr = 5'd7; rd_addra = 5'd7;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_0077;
    tick();
    alu_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd7;
    tick();
    issue_valid = 1'b0;
    @(negedge clk);
    check("collide busy7", {31'd0, busy_mask[0][7]}, 32'd1);
    check("collide hazard_a", {31'd0, hazard_a[0]}, 32'd1);

    // Reset during an in-flight write drops it and clears the scoreboard.
    tick();
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    issue_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h0000_0099;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst enc", {31'd0, enc[0]}, 32'd0);
    check("midrst busy_mask", busy_mask[0], 32'd0);
    check("midrst alu_ready", {31'd0, alu_ready[0]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    alu_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller for the 32x32 register file. The register file has one write port (enc/addrc/datac) and two read ports.
- Shares the single write port between two requesters, the ALU result path and the memory-load path, using a valid/ready handshake and round-robin arbitration.
- Keeps a per-register busy scoreboard: set when an instruction issues with that destination, cleared when its write-back commits. Flags read-after-write hazards for the two read addresses.
- Sits between the execute/memory stages and the register file's write port.

Parameters:
- NREG, 32, number of architectural registers; addresses are log2(NREG) = 5 bits.
- DW, 32, data width.
- ZERO_REG, 1, when 1, register 0 is hardwired: writes to it are accepted but never reach the port, and it never reports busy or hazard.
- RR_EN, 1, arbitration mode: 1 = round-robin; 0 = fixed priority with MEM always winning.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- alu_valid  in  1  ALU write-back request.
- alu_ready  out  1  ALU request granted this cycle.
- alu_addr  in  5  ALU destination register.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  memory write-back request.
- mem_ready  out  1  memory request granted this cycle.
- mem_addr  in  5  memory destination register.
- mem_data  in  DW  load data.
- issue_valid  in  1  instruction issued with a destination register.
- issue_addr  in  5  destination register of the issued instruction.
- rd_addra  in  5  read address of register-file port A.
- rd_addrb  in  5  read address of register-file port B.
- hazard_a  out  1  rd_addra is pending a write.
- hazard_b  out  1  rd_addrb is pending a write.
- busy_mask  out  NREG  current scoreboard, bit i = register i pending.
- enc  out  1  register-file write enable.
- addrc  out  5  register-file write address.
- datac  out  DW  register-file write data.

Behaviour:
- Reset (reset = 0, asynchronous):
  - enc = 0, addrc = 0, datac = 0, busy_mask = 0.
  - Round-robin pointer (last_grant) = MEM, so ALU wins the first tie.
  - alu_ready and mem_ready are forced to 0 while reset is low.
- Arbitration is combinational within the cycle:
  - One requester valid: it gets ready = 1.
  - Both valid with RR_EN = 1: the requester other than last_grant wins.
  - Both valid with RR_EN = 0: MEM wins.
  - At most one ready is high per cycle. ready never depends on ready, only on valid.
- Handshake:
  - A transfer occurs on a rising edge where valid = 1 and ready = 1.
  - A requester must hold valid, addr and data stable until its transfer.
  - last_grant updates to the winner only on a transfer.
- Write-port latency is one cycle. On the edge after a transfer, enc = 1 and addrc/datac carry the winner's addr/data.
- In any cycle with no transfer, enc is 0 on the following cycle; addrc/datac hold their last value.
- With ZERO_REG = 1 and winner addr = 0: the transfer completes (ready = 1), but enc stays 0 on the next cycle.
- Scoreboard, updated on each rising edge:
  - issue_valid sets busy[issue_addr].
  - A committed write (enc = 1 in the current cycle) clears busy[addrc].
  - Same-register set and clear on the same edge: set wins.
  - Issue to register 0 with ZERO_REG = 1 is ignored.
- hazard_a = busy[rd_addra] and hazard_b = busy[rd_addrb], both combinational from the registered scoreboard.
  - The hazard clears on the edge where the write commits, so a read in the following cycle sees the new register-file data.
  - Register 0 never raises a hazard when ZERO_REG = 1.
- A request without a prior issue is still written; clearing an already-clear busy bit is harmless.
- Reset mid-operation: an in-flight write is dropped (enc = 0 immediately), all busy bits clear, and a pending handshake is lost. Requesters must re-present after reset releases.

Test Plan:
- Reset: hold reset = 0 for 3 cycles with alu_valid = 1 → alu_ready = 0, enc = 0, busy_mask = 0. Release → alu_ready = 1 in the same cycle.
- Single write:
  - Stimulus: issue_addr = 5; next cycle alu_valid = 1, alu_addr = 5, alu_data = 0xDEADBEEF.
  - Response: hazard_a = 1 while rd_addra = 5. enc = 1, addrc = 5, datac = 0xDEADBEEF one cycle after the transfer; hazard_a = 0 on the cycle after that.
- Round-robin: both requesters valid continuously, ALU addr 3 and MEM addr 4, RR_EN = 1 → grants alternate ALU, MEM, ALU, MEM; addrc sequence 3, 4, 3, 4; enc high every cycle.
- Fixed priority: RR_EN = 0, both valid for 4 cycles → mem_ready = 1 every cycle, alu_ready = 0 throughout.
- Zero register: ZERO_REG = 1, issue_addr = 0, then mem write to addr 0 with data 0x1234 → mem_ready = 1, enc stays 0, busy_mask[0] = 0, hazard_b = 0 with rd_addrb = 0.
- Set/clear collision: busy[7] = 1 and a write to 7 commits on the same edge that issue_addr = 7 → busy[7] remains 1 afterwards.
